// File: rtl/cadence_filt_mc.sv
// cadence_filt_mc: multi-channel cadence sensor conditioner.
// Each channel has its own synchroniser, saturating-counter debounce and
// rise/fall pulse generator. It also measures the rise-to-rise period and
// flags a stall when no rise arrives within the measurable range.

module cadence_filt_ch #(
  parameter int STBL_W   = 16,
  parameter int FAST_SIM = 1,
  parameter int PER_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cad_in,
  output logic             cad_filt,
  output logic             cad_rise,
  output logic             cad_fall,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             stalled
);

  // Stability threshold: short in simulation builds, full counter range otherwise.
  localparam logic [STBL_W-1:0] TH      = (FAST_SIM != 0) ? STBL_W'(10'd511) : {STBL_W{1'b1}};
  localparam logic [PER_W-1:0]  PMAX    = {PER_W{1'b1}};
  localparam logic [PER_W-1:0]  PMAX_M1 = {{(PER_W-1){1'b1}}, 1'b0};
  localparam logic [PER_W-1:0]  PONE    = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic [STBL_W-1:0] CONE    = {{(STBL_W-1){1'b0}}, 1'b1};

  logic              s1_r;
  logic              s2_r;
  logic              s3_r;
  logic              chg_s;
  logic [STBL_W-1:0] cnt_r;
  logic [STBL_W-1:0] cnt_nxt_s;
  logic              filt_r;
  logic              filt_nxt_s;
  logic              rise_r;
  logic              fall_r;

  logic [PER_W-1:0]  pcnt_r;
  logic [PER_W-1:0]  pcnt_nxt_s;
  logic [PER_W-1:0]  period_r;
  logic [PER_W-1:0]  period_nxt_s;
  logic              armed_r;
  logic              armed_nxt_s;
  logic              vld_r;
  logic              vld_nxt_s;
  logic              stalled_r;
  logic              stalled_nxt_s;

  // Debounce: restart the stability count on any synchronised change, saturate at TH,
  // and only let the synchronised level through once it has been stable long enough.
  always_comb begin
    chg_s = s2_r ^ s3_r;
    if (chg_s) begin
      cnt_nxt_s = {STBL_W{1'b0}};
    end else if (cnt_r == TH) begin
      cnt_nxt_s = TH;
    end else begin
      cnt_nxt_s = cnt_r + CONE;
    end
    if (cnt_r == TH) begin
      filt_nxt_s = s3_r;
    end else begin
      filt_nxt_s = filt_r;
    end
  end

  // Synchronise the raw input, advance the debounce counter and register level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s3_r   <= 1'b0;
      cnt_r  <= {STBL_W{1'b0}};
      filt_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      s1_r   <= cad_in;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      cnt_r  <= cnt_nxt_s;
      filt_r <= filt_nxt_s;
      // Pulses are aligned with the first cycle of the new filtered level.
      rise_r <= filt_nxt_s & ~filt_r;
      fall_r <= ~filt_nxt_s & filt_r;
    end
  end

  // Period measurement: a rise latches the running count (when armed) and restarts it;
  // reaching the top of the counter means the period is unknown, so disarm and flag a stall.
  always_comb begin
    pcnt_nxt_s    = pcnt_r;
    period_nxt_s  = period_r;
    armed_nxt_s   = armed_r;
    vld_nxt_s     = 1'b0;
    stalled_nxt_s = stalled_r;
    if (rise_r) begin
      if (armed_r) begin
        period_nxt_s = pcnt_r;
      end else begin
        period_nxt_s = period_r;
      end
      vld_nxt_s     = armed_r;
      pcnt_nxt_s    = PONE;
      armed_nxt_s   = 1'b1;
      stalled_nxt_s = 1'b0;
    end else if ((pcnt_r == PMAX_M1) || (pcnt_r == PMAX)) begin
      pcnt_nxt_s    = PMAX;
      armed_nxt_s   = 1'b0;
      stalled_nxt_s = 1'b1;
    end else begin
      pcnt_nxt_s    = pcnt_r + PONE;
    end
  end

  // Period state register; stalled starts high because no period is known after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r    <= {PER_W{1'b0}};
      period_r  <= {PER_W{1'b0}};
      armed_r   <= 1'b0;
      vld_r     <= 1'b0;
      stalled_r <= 1'b1;
    end else begin
      pcnt_r    <= pcnt_nxt_s;
      period_r  <= period_nxt_s;
      armed_r   <= armed_nxt_s;
      vld_r     <= vld_nxt_s;
      stalled_r <= stalled_nxt_s;
    end
  end

  assign cad_filt   = filt_r;
  assign cad_rise   = rise_r;
  assign cad_fall   = fall_r;
  assign period     = period_r;
  assign period_vld = vld_r;
  assign stalled    = stalled_r;

endmodule

module cadence_filt_mc #(
  parameter int NUM_CH   = 2,
  parameter int STBL_W   = 16,
  parameter int FAST_SIM = 1,
  parameter int PER_W    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       cad_in,
  output logic [NUM_CH-1:0]       cad_filt,
  output logic [NUM_CH-1:0]       cad_rise,
  output logic [NUM_CH-1:0]       cad_fall,
  output logic [NUM_CH*PER_W-1:0] period,
  output logic [NUM_CH-1:0]       period_vld,
  output logic [NUM_CH-1:0]       stalled
);

  // Channels share nothing but clock and reset.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cadence_filt_ch #(
      .STBL_W   (STBL_W),
      .FAST_SIM (FAST_SIM),
      .PER_W    (PER_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cad_in     (cad_in[i]),
      .cad_filt   (cad_filt[i]),
      .cad_rise   (cad_rise[i]),
      .cad_fall   (cad_fall[i]),
      .period     (period[i*PER_W +: PER_W]),
      .period_vld (period_vld[i]),
      .stalled    (stalled[i])
    );
  end

endmodule

// File: tb/tb_cadence_filt_mc.sv
// Testbench for cadence_filt_mc: directed scenarios plus randomized toggling,
// checked every cycle against a run-length/timestamp reference model.

module tb_cadence_filt_mc;

  localparam int NUM_CH = 2;
  localparam int STBL_W = 16;
  localparam int FAST_SIM = 1;
  localparam int PER_W = 12;
  localparam int TH = 511;
  localparam int PMAX = 4095;
  localparam int OW = 5*NUM_CH + NUM_CH*PER_W;

  logic clk;
  logic rst;
  logic [NUM_CH-1:0] cad_in;
  logic [NUM_CH-1:0] cad_filt, cad_rise, cad_fall, period_vld, stalled;
  logic [NUM_CH*PER_W-1:0] period;

  int total = 0;
  int bad = 0;

  cadence_filt_mc #(.NUM_CH(NUM_CH), .STBL_W(STBL_W), .FAST_SIM(FAST_SIM), .PER_W(PER_W)) dut (
    .clk(clk), .rst(rst), .cad_in(cad_in), .cad_filt(cad_filt), .cad_rise(cad_rise),
    .cad_fall(cad_fall), .period(period), .period_vld(period_vld), .stalled(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Filtered level follows the input sample taken 3 clocks earlier once that
  // sample ends a run of at least TH+1 equal samples. Rises are time-stamped;
  // the period is the difference of consecutive rise timestamps when below PMAX.
  int m_t;
  logic [3:0] m_in [NUM_CH];
  int m_run [NUM_CH][4];
  bit m_have [NUM_CH];
  int m_last [NUM_CH];
  logic [NUM_CH-1:0] e_filt, e_rise, e_fall, e_vld, e_stalled;
  logic [NUM_CH*PER_W-1:0] e_period;

  function automatic logic new_filt(input int run, input logic smp, input logic cur);
    return (run >= TH + 1) ? smp : cur;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0;
      e_filt <= '0; e_rise <= '0; e_fall <= '0; e_vld <= '0;
      e_stalled <= '1; e_period <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_in[c] <= 4'b0000;
        m_have[c] <= 1'b0;
        m_last[c] <= 0;
        for (int k = 0; k < 4; k++) m_run[c][k] <= 1000000;
      end
    end else begin
      m_t <= m_t + 1;
      for (int c = 0; c < NUM_CH; c++) begin
        m_in[c] <= {m_in[c][2:0], cad_in[c]};
        m_run[c][0] <= (cad_in[c] == m_in[c][0]) ? ((m_run[c][0] < 1000000) ? m_run[c][0] + 1 : m_run[c][0]) : 1;
        for (int k = 1; k < 4; k++) m_run[c][k] <= m_run[c][k-1];
        e_filt[c] <= new_filt(m_run[c][2], m_in[c][2], e_filt[c]);
        e_rise[c] <= new_filt(m_run[c][2], m_in[c][2], e_filt[c]) & ~e_filt[c];
        e_fall[c] <= ~new_filt(m_run[c][2], m_in[c][2], e_filt[c]) & e_filt[c];
        if (e_rise[c]) begin
          if (m_have[c] && (m_t - m_last[c]) <= PMAX - 1) begin
            e_vld[c] <= 1'b1;
            e_period[c*PER_W +: PER_W] <= PER_W'(m_t - m_last[c]);
          end else begin
            e_vld[c] <= 1'b0;
          end
          m_have[c] <= 1'b1;
          m_last[c] <= m_t;
          e_stalled[c] <= 1'b0;
        end else begin
          e_vld[c] <= 1'b0;
          e_stalled[c] <= !m_have[c] || ((m_t + 1 - m_last[c]) >= PMAX);
        end
      end
    end
  end

  wire [OW-1:0] obs_w = {cad_filt, cad_rise, cad_fall, period, period_vld, stalled};
  wire [OW-1:0] exp_w = {e_filt, e_rise, e_fall, e_period, e_vld, e_stalled};

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cad_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if (cad_filt !== 2'b00 || cad_rise !== 2'b00 || cad_fall !== 2'b00 || period !== '0 ||
        period_vld !== 2'b00 || stalled !== 2'b11) begin
      bad++; $display("FAIL reset_vals got=%h required filt/rise/fall/vld=0 period=0 stalled=3", obs_w);
    end
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL reset_idle n=%0d got=%h exp=%h", n, obs_w, exp_w); end
    end
  endtask

  task automatic test_step();
    int rise_at, nrise, fall_at, nfall;
    rise_at = -1; nrise = 0; fall_at = -1; nfall = 0;
    cad_in[0] = 1'b1;
    for (int n = 1; n <= 530; n++) begin
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL step_model n=%0d got=%h exp=%h", n, obs_w, exp_w); end
      total++;
      if (cad_filt[1] !== 1'b0 || cad_rise[1] !== 1'b0) begin
        bad++; $display("FAIL step_ch1 n=%0d got filt=%b rise=%b exp 0 0", n, cad_filt[1], cad_rise[1]);
      end
      if (cad_rise[0]) nrise++;
      if (cad_filt[0] === 1'b1 && rise_at < 0) rise_at = n;
    end
    total++;
    if (rise_at != TH + 4) begin bad++; $display("FAIL step_latency got=%0d exp=%0d", rise_at, TH + 4); end
    total++;
    if (nrise != 1) begin bad++; $display("FAIL step_rise_count got=%0d exp=1", nrise); end
    cad_in[0] = 1'b0;
    for (int n = 1; n <= 530; n++) begin
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL step_fall_model n=%0d got=%h exp=%h", n, obs_w, exp_w); end
      if (cad_fall[0]) nfall++;
      if (cad_filt[0] === 1'b0 && fall_at < 0) fall_at = n;
    end
    total++;
    if (fall_at != TH + 4 || nfall != 1) begin
      bad++; $display("FAIL step_fall got at=%0d cnt=%0d exp at=%0d cnt=1", fall_at, nfall, TH + 4);
    end
  endtask

  task automatic test_glitch();
    int lens [3];
    int npulse;
    lens[0] = 1; lens[1] = 100; lens[2] = 510;
    npulse = 0;
    for (int g = 0; g < 3; g++) begin
      cad_in[0] = 1'b1;
      for (int n = 0; n < lens[g] + 700; n++) begin
        @(negedge clk);
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL glitch_model len=%0d n=%0d got=%h exp=%h", lens[g], n, obs_w, exp_w); end
        if (cad_rise[0] || cad_fall[0] || cad_filt[0]) npulse++;
        if (n == lens[g] - 1) cad_in[0] = 1'b0;
      end
    end
    total++;
    if (npulse != 0) begin bad++; $display("FAIL glitch_pass got=%0d cycles with activity exp=0", npulse); end
  endtask

  task automatic test_period();
    int nrise, nvld, first_n;
    nrise = 0; nvld = 0; first_n = -1;
    for (int n = 0; n < 10000; n++) begin
      cad_in[1] = ((n % 2000) < 1000);
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL period_model n=%0d got=%h exp=%h", n, obs_w, exp_w); end
      if (cad_rise[1]) begin nrise++; if (first_n < 0) first_n = n; end
      if (first_n >= 0 && n == first_n + 1) begin
        total++;
        if (stalled[1] !== 1'b0 || period_vld[1] !== 1'b0) begin
          bad++; $display("FAIL period_first got stalled=%b vld=%b exp 0 0", stalled[1], period_vld[1]);
        end
      end
      if (period_vld[1]) begin
        nvld++;
        total++;
        if (period[PER_W +: PER_W] !== PER_W'(2000)) begin
          bad++; $display("FAIL period_value got=%0d exp=2000", period[PER_W +: PER_W]);
        end
      end
    end
    total++;
    if (nrise != 5 || nvld != 4) begin bad++; $display("FAIL period_counts got rises=%0d vlds=%0d exp 5 4", nrise, nvld); end
  endtask

  task automatic test_stall();
    int lvl [8];
    int len [8];
    int rises [$];
    int vlds [$];
    int n, stall_n, gap_d;
    logic st_prev;
    gap_d = 1400 + $urandom_range(0, 2000);
    lvl[0] = 1; len[0] = 800;   lvl[1] = 0; len[1] = 800;
    lvl[2] = 1; len[2] = 800;   lvl[3] = 0; len[3] = 5000;
    lvl[4] = 1; len[4] = 800;   lvl[5] = 0; len[5] = gap_d - 800;
    lvl[6] = 1; len[6] = 800;   lvl[7] = 0; len[7] = 700;
    n = 0; stall_n = -1; st_prev = stalled[0];
    for (int s = 0; s < 8; s++) begin
      cad_in[0] = lvl[s][0];
      for (int i = 0; i < len[s]; i++) begin
        @(negedge clk);
        n++;
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL stall_model n=%0d got=%h exp=%h", n, obs_w, exp_w); end
        if (cad_rise[0]) rises.push_back(n);
        if (period_vld[0]) vlds.push_back(int'(period[PER_W-1:0]));
        if (stalled[0] && !st_prev && stall_n < 0 && rises.size() == 2) stall_n = n;
        st_prev = stalled[0];
      end
    end
    total++;
    if (rises.size() != 4 || stall_n < 0 || stall_n - rises[1] != PMAX) begin
      bad++; $display("FAIL stall_time got rises=%0d delay=%0d exp 4 %0d", rises.size(),
                      (rises.size() > 1) ? stall_n - rises[1] : -1, PMAX);
    end
    total++;
    if (vlds.size() != 2) begin
      bad++; $display("FAIL stall_vld_count got=%0d exp=2", vlds.size());
    end else if (vlds[0] != 1600 || vlds[1] != gap_d) begin
      bad++; $display("FAIL stall_periods got=%0d,%0d exp=1600,%0d", vlds[0], vlds[1], gap_d);
    end
  endtask

  task automatic test_simul();
    int both_r, both_f;
    both_r = 0; both_f = 0;
    for (int ph = 0; ph < 2; ph++) begin
      cad_in = (ph == 0) ? 2'b11 : 2'b00;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL simul_model n=%0d got=%h exp=%h", n, obs_w, exp_w); end
        total++;
        if (cad_filt[0] !== cad_filt[1] || cad_rise[0] !== cad_rise[1] || cad_fall[0] !== cad_fall[1]) begin
          bad++; $display("FAIL simul_match n=%0d got filt=%b rise=%b fall=%b exp equal bits", n, cad_filt, cad_rise, cad_fall);
        end
        if (cad_rise == 2'b11) both_r++;
        if (cad_fall == 2'b11) both_f++;
      end
    end
    total++;
    if (both_r != 1 || both_f != 1) begin bad++; $display("FAIL simul_pulses got rise=%0d fall=%0d exp 1 1", both_r, both_f); end
    // randomized independent / simultaneous toggling, boundary glitch lengths included
    for (int s = 0; s < 20; s++) begin
      int sel, seg, mode;
      sel = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      if (sel == 0) seg = $urandom_range(1, 400);
      else if (sel == 1) seg = $urandom_range(505, 515);
      else seg = $urandom_range(520, 2000);
      if (mode == 0) cad_in = ~cad_in;
      else if (mode == 1) cad_in[0] = ~cad_in[0];
      else cad_in[1] = ~cad_in[1];
      for (int n = 0; n < seg; n++) begin
        @(negedge clk);
        total++;
        if (obs_w !== exp_w) begin bad++; $display("FAIL random_model seg=%0d n=%0d got=%h exp=%h", s, n, obs_w, exp_w); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rise_at, early, nvld;
    rise_at = -1; early = 0; nvld = 0;
    cad_in = 2'b11;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL rmid_pre n=%0d got=%h exp=%h", n, obs_w, exp_w); end
    end
    cad_in = 2'b10;
    repeat (200) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (cad_filt !== 2'b00 || cad_rise !== 2'b00 || cad_fall !== 2'b00 || period !== '0 ||
        period_vld !== 2'b00 || stalled !== 2'b11) begin
      bad++; $display("FAIL rmid_async got=%h required filt/rise/fall/vld=0 period=0 stalled=3", obs_w);
    end
    repeat (2) @(negedge clk);
    total++;
    if (obs_w !== exp_w) begin bad++; $display("FAIL rmid_held got=%h exp=%h", obs_w, exp_w); end
    rst = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      total++;
      if (obs_w !== exp_w) begin bad++; $display("FAIL rmid_post n=%0d got=%h exp=%h", n, obs_w, exp_w); end
      if (n <= 100 && (cad_rise != 2'b00 || cad_fall != 2'b00)) early++;
      if (cad_rise[1] && rise_at < 0) rise_at = n;
      if (period_vld != 2'b00) nvld++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL rmid_release_pulse got=%0d exp=0", early); end
    total++;
    if (rise_at != TH + 4 || nvld != 0) begin
      bad++; $display("FAIL rmid_rise got at=%0d vlds=%0d exp at=%0d vlds=0", rise_at, nvld, TH + 4);
    end
  endtask

  initial begin
    rst = 1'b0;
    cad_in = '0;
    #1;
    test_reset();
    test_step();
    test_glitch();
    test_period();
    test_stall();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
